bsg_skid_buffer_reset_en: RTL and testbench



---
 rtl/bsg_skid_buffer_pkg.sv | 16 +
 rtl/bsg_dff_async_reset_en.sv | 31 +++
 rtl/bsg_skid_buffer_reset_en.sv | 148 ++++++++++++++
 tb/tb_bsg_skid_buffer_reset_en.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_skid_buffer_pkg.sv
// Shared types and constants for the two-entry skid buffer.
//
// Contents:
//   bsg_skid_state_e         occupancy state (EMPTY, ONE, FULL) in a 2-bit encoding
//   StallCntWidthDefault     default width of the optional consumer stall counter
package bsg_skid_buffer_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } bsg_skid_state_e;

  localparam int unsigned StallCntWidthDefault = 16;

endpackage

// File: rtl/bsg_dff_async_reset_en.sv
// Enabled data register with asynchronous, active-low clear.
//
// Ports:
//   clk_i      clock, captures on posedge
//   reset_n_i  asynchronous active-low reset, clears data_o to 0
//   en_i       load enable
//   data_i     next value, loaded when en_i=1
//   data_o     registered value
module bsg_dff_async_reset_en #(
  parameter int unsigned width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               en_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  logic [width_p-1:0] data_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= data_i;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/bsg_skid_buffer_reset_en.sv
// Two-entry ready/valid skid buffer with a registered ready_o.
//
// The head register drives data_o; the skid register catches the word accepted while the
// head is occupied and not being consumed. ready_o and v_o decode straight from the state
// register, so neither depends combinationally on the consumer or producer.
//
// Ports:
//   clk_i        clock
//   reset_n_i    asynchronous active-low reset
//   v_i, data_i  producer handshake and data; accepted when v_i & ready_o
//   ready_o      buffer can accept (state != FULL)
//   v_o, data_o  head-of-buffer valid and data
//   yumi_i       consumer takes data_o this cycle; only meaningful while v_o=1
//   stall_cnt_o  saturating count of cycles with v_o=1 & yumi_i=0
//                (only when BSG_SKID_BUFFER_STALL_CNT_EN is defined)
module bsg_skid_buffer_reset_en
  import bsg_skid_buffer_pkg::*;
#(
  parameter int unsigned width_p     = 32,
  parameter int unsigned cnt_width_p = StallCntWidthDefault
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   v_i,
  input  logic [width_p-1:0]     data_i,
  output logic                   ready_o,
  output logic                   v_o,
  output logic [width_p-1:0]     data_o,
  input  logic                   yumi_i
`ifdef BSG_SKID_BUFFER_STALL_CNT_EN
  ,
  output logic [cnt_width_p-1:0] stall_cnt_o
`endif
);

  if (width_p == 0 || cnt_width_p == 0) begin : g_bad_param
    $error("bsg_skid_buffer_reset_en: width_p and cnt_width_p must be non-zero");
  end

  bsg_skid_state_e    state_q, state_d;
  logic               enq, deq;
  logic               head_en, skid_en;
  logic [width_p-1:0] head_d, head_q, skid_q;

  assign ready_o = (state_q != FULL);
  assign v_o     = (state_q != EMPTY);
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;

  always_comb begin
    state_d = state_q;
    head_en = 1'b0;
    skid_en = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (enq) begin
          state_d = ONE;
          head_en = 1'b1;
        end
      end
      ONE: begin
        if (enq && deq) begin
          head_en = 1'b1;
        end else if (enq) begin
          state_d = FULL;
          skid_en = 1'b1;
        end else if (deq) begin
          // Head keeps its stale value; v_o masks it.
          state_d = EMPTY;
        end
      end
      FULL: begin
        // ready_o is low here, so only a dequeue can happen.
        if (deq) begin
          state_d = ONE;
          head_en = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Head refills from the skid entry when draining FULL, otherwise from the producer.
  assign head_d = (state_q == FULL) ? skid_q : data_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  bsg_dff_async_reset_en #(
    .width_p(width_p)
  ) u_head (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .en_i     (head_en),
    .data_i   (head_d),
    .data_o   (head_q)
  );

  bsg_dff_async_reset_en #(
    .width_p(width_p)
  ) u_skid (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .en_i     (skid_en),
    .data_i   (data_i),
    .data_o   (skid_q)
  );

  assign data_o = head_q;

`ifdef BSG_SKID_BUFFER_STALL_CNT_EN
  logic [cnt_width_p-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (v_o && !yumi_i && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

`ifndef SYNTHESIS
  // A yumi with nothing to take is ignored by the state machine, but it points at a
  // consumer bug, so make it visible.
  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(yumi_i && !v_o))
      else $warning("bsg_skid_buffer_reset_en: yumi_i asserted while v_o is low");
    end
  end
`endif

endmodule

// File: tb/tb_bsg_skid_buffer_reset_en.sv
module tb_bsg_skid_buffer_reset_en;

  logic        clk_i;
  logic        reset_n_i;
  logic        v_i;
  logic [31:0] data_i;
  logic        ready_o;
  logic        v_o;
  logic [31:0] data_o;
  logic        yumi_i;
`ifdef BSG_SKID_BUFFER_STALL_CNT_EN
  logic [1:0]  stall_cnt_o;
`endif

  int unsigned checks;
  int unsigned errors;

  bsg_skid_buffer_reset_en #(
    .width_p    (32),
    .cnt_width_p(2)
  ) dut (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .v_i        (v_i),
    .data_i     (data_i),
    .ready_o    (ready_o),
    .v_o        (v_o),
    .data_o     (data_o),
    .yumi_i     (yumi_i)
`ifdef BSG_SKID_BUFFER_STALL_CNT_EN
    ,
    .stall_cnt_o(stall_cnt_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_reset();
    reset_n_i = 1'b0;
    v_i       = 1'b0;
    yumi_i    = 1'b0;
    data_i    = '0;
    #2;
    reset_n_i = 1'b1;
    step();
  endtask

  task automatic test_reset();
    reset_n_i = 1'b1;
    v_i = 1'b0; yumi_i = 1'b0; data_i = '0;
    #1;
    reset_n_i = 1'b0;
    #10;
    checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL reset_v_o got %b want 0", v_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready_o); end
    checks++; if (data_o !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", data_o); end
    reset_n_i = 1'b1;
    step();
    // Fill to FULL, then reset asynchronously mid-cycle.
    v_i = 1'b1; data_i = 32'h5;
    step();
    data_i = 32'h6;
    step();
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", ready_o); end
    #2;
    reset_n_i = 1'b0;
    v_i = 1'b0;
    #1;
    checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL midrst_v_o got %b want 0", v_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", ready_o); end
    checks++; if (data_o !== 32'h0) begin errors++; $display("FAIL midrst_data got %h want 0", data_o); end
    #1;
    reset_n_i = 1'b1;
    step();
    step();
    checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL post_rst_v_o got %b want 0", v_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %b want 1", ready_o); end
  endtask

  task automatic test_streaming();
    int unsigned send_idx, expect_idx, iters;
    send_idx = 1; expect_idx = 1; iters = 0;
    while (expect_idx <= 100 && iters < 300) begin
      v_i    = (send_idx <= 100);
      data_i = send_idx;
      yumi_i = v_o;
      if (v_o) begin
        checks++;
        if (data_o !== expect_idx) begin
          errors++; $display("FAIL stream_data got %0d want %0d", data_o, expect_idx);
        end
        expect_idx++;
      end
      checks++;
      if (ready_o !== 1'b1) begin errors++; $display("FAIL stream_ready got %b want 1", ready_o); end
      if (v_i && ready_o) send_idx++;
      step();
      iters++;
    end
    v_i = 1'b0; yumi_i = 1'b0;
    checks++;
    if (iters !== 101) begin errors++; $display("FAIL stream_cycles got %0d want 101", iters); end
    checks++;
    if (v_o !== 1'b0) begin errors++; $display("FAIL stream_end_v_o got %b want 0", v_o); end
  endtask

  task automatic test_backpressure();
    v_i = 1'b1; data_i = 32'hA; yumi_i = 1'b0;
    step();
    data_i = 32'hB;
    step();
    v_i = 1'b0;
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready got %b want 0", ready_o); end
    checks++; if (data_o !== 32'hA) begin errors++; $display("FAIL bp_head got %h want a", data_o); end
    checks++; if (v_o !== 1'b1) begin errors++; $display("FAIL bp_v_o got %b want 1", v_o); end
    yumi_i = 1'b1;
    step();
    checks++; if (data_o !== 32'hB) begin errors++; $display("FAIL bp_drain_data got %h want b", data_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL bp_drain_ready got %b want 1", ready_o); end
    step();
    yumi_i = 1'b0;
    checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL bp_empty_v_o got %b want 0", v_o); end
  endtask

  task automatic test_held_producer();
    logic [31:0] got [4];
    int unsigned n;
    logic        c_sent;
    logic [31:0] want [3];
    want[0] = 32'h1A; want[1] = 32'h1B; want[2] = 32'hC;
    n = 0; c_sent = 1'b0;
    for (int i = 0; i < 4; i++) got[i] = '0;
    v_i = 1'b1; data_i = 32'h1A; yumi_i = 1'b0;
    step();
    data_i = 32'h1B;
    step();
    data_i = 32'hC;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL held_ready[%0d] got %b want 0", i, ready_o); end
      checks++; if (data_o !== 32'h1A) begin errors++; $display("FAIL held_head[%0d] got %h want 1a", i, data_o); end
    end
    for (int i = 0; i < 20 && !(c_sent && !v_o); i++) begin
      yumi_i = v_o;
      if (v_o) begin
        if (n < 4) got[n] = data_o;
        n++;
      end
      if (v_i && ready_o) c_sent = 1'b1;
      step();
      if (c_sent) v_i = 1'b0;
    end
    v_i = 1'b0; yumi_i = 1'b0;
    checks++; if (n !== 3) begin errors++; $display("FAIL held_count got %0d want 3", n); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got[i] !== want[i]) begin
        errors++; $display("FAIL held_order[%0d] got %h want %h", i, got[i], want[i]);
      end
    end
  endtask

  task automatic test_illegal_yumi();
    // Buffer is EMPTY with stale head 32'hC from the previous scenario.
    v_i = 1'b0; yumi_i = 1'b1;
    step();
    step();
    yumi_i = 1'b0;
    checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL illegal_v_o got %b want 0", v_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL illegal_ready got %b want 1", ready_o); end
    checks++; if (data_o !== 32'hC) begin errors++; $display("FAIL illegal_data got %h want c", data_o); end
    // Still EMPTY: two accepts must be needed to fill.
    v_i = 1'b1; data_i = 32'hD;
    step();
    v_i = 1'b0;
    checks++; if (data_o !== 32'hD) begin errors++; $display("FAIL illegal_next_data got %h want d", data_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL illegal_next_ready got %b want 1", ready_o); end
    yumi_i = 1'b1;
    step();
    yumi_i = 1'b0;
  endtask

`ifdef BSG_SKID_BUFFER_STALL_CNT_EN
  task automatic test_stall_cnt();
    logic [1:0] want [5];
    want[0] = 2'd0; want[1] = 2'd1; want[2] = 2'd2; want[3] = 2'd3; want[4] = 2'd3;
    pulse_reset();
    v_i = 1'b1; data_i = 32'hE;
    step();
    v_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (stall_cnt_o !== want[i]) begin
        errors++; $display("FAIL stall_cnt[%0d] got %0d want %0d", i, stall_cnt_o, want[i]);
      end
      if (i < 4) step();
    end
    yumi_i = 1'b1;
    step();
    yumi_i = 1'b0;
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_held_producer();
    test_illegal_yumi();
`ifdef BSG_SKID_BUFFER_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
